aesl_deadlock_watchdog: RTL and testbench

//  Parametrised successor to the per-instance deadlock monitors in the cosim testbench.
//  - Combines per-axis block flags and per-sub-instance block/idle flags into a raw block

---
 rtl/aesl_deadlock_watchdog.sv | 125 ++++++++++++
 tb/tb_aesl_deadlock_watchdog.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/aesl_deadlock_watchdog.sv
// rtl/aesl_deadlock_watchdog.sv - deadlock watchdog: persistence-filtered block flag with source latch and cycle counter
module aesl_deadlock_watchdog #(
  parameter int                N_AXIS      = 4,
  parameter logic [N_AXIS-1:0] AXIS_MASK   = 4'b1110,
  parameter int                N_SUB       = 3,
  parameter int                HOLD_CYCLES = 1,
  parameter bit                STICKY      = 1'b0,
  parameter int                CNT_W       = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    clear,
  input  logic [N_AXIS-1:0]       axis_block_sigs,
  input  logic [N_SUB-1:0]        inst_idle_sigs,
  input  logic [N_SUB-1:0]        inst_block_sigs,
  output logic                    block,
  output logic                    block_pulse,
  output logic [N_AXIS+N_SUB-1:0] block_src,
  output logic [CNT_W-1:0]        block_cycles
);

  localparam int HCW   = $clog2(HOLD_CYCLES + 1);
  localparam int SRC_W = N_AXIS + N_SUB;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    BLOCKED = 2'd2
  } state_t;

  state_t             state_q;
  logic [HCW-1:0]     cnt_q;
  logic               block_q;
  logic               pulse_q;
  logic [SRC_W-1:0]   src_q;
  logic [CNT_W-1:0]   cycles_q;

  logic [SRC_W-1:0]   src_d;
  logic               raw_d;
  logic [CNT_W-1:0]   cycles_d;

  // An idle sub-instance is waiting by design, so its block flag is not evidence of a hang.
  assign src_d    = {inst_block_sigs & ~inst_idle_sigs, axis_block_sigs & AXIS_MASK};
  assign raw_d    = |src_d;
  assign cycles_d = (&cycles_q) ? cycles_q : cycles_q + CNT_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      block_q  <= 1'b0;
      pulse_q  <= 1'b0;
      src_q    <= '0;
      cycles_q <= '0;
    end else if (!enable || clear) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      block_q  <= 1'b0;
      pulse_q  <= 1'b0;
      src_q    <= '0;
      cycles_q <= '0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (raw_d) begin
            if (HOLD_CYCLES == 1) begin
              state_q  <= BLOCKED;
              cnt_q    <= '0;
              block_q  <= 1'b1;
              pulse_q  <= 1'b1;
              src_q    <= src_d;
              cycles_q <= CNT_W'(1);
            end else begin
              state_q <= ARMED;
              cnt_q   <= HCW'(1);
            end
          end
        end
        ARMED: begin
          if (!raw_d) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == HCW'(HOLD_CYCLES - 1)) begin
            state_q  <= BLOCKED;
            cnt_q    <= '0;
            block_q  <= 1'b1;
            pulse_q  <= 1'b1;
            src_q    <= src_d;
            cycles_q <= CNT_W'(1);
          end else begin
            cnt_q <= cnt_q + HCW'(1);
          end
        end
        BLOCKED: begin
          if (STICKY) begin
            src_q    <= src_q | src_d;
            cycles_q <= cycles_d;
          end else if (!raw_d) begin
            // Cycle count is kept so the bench can read the length of the last episode.
            state_q <= IDLE;
            block_q <= 1'b0;
            src_q   <= '0;
          end else begin
            src_q    <= src_q | src_d;
            cycles_q <= cycles_d;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          block_q <= 1'b0;
          src_q   <= '0;
        end
      endcase
    end
  end

  assign block        = block_q;
  assign block_pulse  = pulse_q;
  assign block_src    = src_q;
  assign block_cycles = cycles_q;

endmodule

// File: tb/tb_aesl_deadlock_watchdog.sv
// tb/tb_aesl_deadlock_watchdog.sv - directed vector bench for aesl_deadlock_watchdog
module tb_aesl_deadlock_watchdog;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       clear = 1'b0;
  logic [3:0] axis = '0;
  logic [2:0] idle = '0;
  logic [2:0] blk = '0;

  logic        block_a, pulse_a;
  logic [6:0]  src_a;
  logic [15:0] cyc_a;
  logic        block_b, pulse_b;
  logic [6:0]  src_b;
  logic [15:0] cyc_b;
  logic        block_c, pulse_c;
  logic [6:0]  src_c;
  logic [15:0] cyc_c;
  logic        block_d, pulse_d;
  logic [6:0]  src_d;
  logic [2:0]  cyc_d;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  aesl_deadlock_watchdog dut_a (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .axis_block_sigs(axis), .inst_idle_sigs(idle), .inst_block_sigs(blk),
    .block(block_a), .block_pulse(pulse_a), .block_src(src_a), .block_cycles(cyc_a));

  aesl_deadlock_watchdog #(.HOLD_CYCLES(4)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .axis_block_sigs(axis), .inst_idle_sigs(idle), .inst_block_sigs(blk),
    .block(block_b), .block_pulse(pulse_b), .block_src(src_b), .block_cycles(cyc_b));

  aesl_deadlock_watchdog #(.STICKY(1'b1)) dut_c (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .axis_block_sigs(axis), .inst_idle_sigs(idle), .inst_block_sigs(blk),
    .block(block_c), .block_pulse(pulse_c), .block_src(src_c), .block_cycles(cyc_c));

  aesl_deadlock_watchdog #(.CNT_W(3)) dut_d (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .axis_block_sigs(axis), .inst_idle_sigs(idle), .inst_block_sigs(blk),
    .block(block_d), .block_pulse(pulse_d), .block_src(src_d), .block_cycles(cyc_d));

  typedef struct {
    logic [3:0]  axis;
    logic [2:0]  idle;
    logic [2:0]  blk;
    logic        clr;
    logic        en;
    logic        exp_block;
    logic        exp_pulse;
    logic [6:0]  exp_src;
    logic [15:0] exp_cyc;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [2:0] i, input logic [2:0] b,
                       input logic c, input logic e);
    @(negedge clock);
    axis = a; idle = i; blk = b; clear = c; enable = e;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; axis = '0; idle = '0; blk = '0; clear = 1'b0; enable = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int npulse;
    vecs[0]  = '{4'b0100, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 7'b0000100, 16'd1};
    vecs[1]  = '{4'b0000, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0000000, 16'd1};
    vecs[2]  = '{4'b0001, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0000000, 16'd1};
    vecs[3]  = '{4'b0001, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0000000, 16'd1};
    vecs[4]  = '{4'b0000, 3'b010, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0000000, 16'd1};
    vecs[5]  = '{4'b0000, 3'b000, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 7'b0100000, 16'd1};
    vecs[6]  = '{4'b1000, 3'b000, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 7'b0101000, 16'd2};
    vecs[7]  = '{4'b1000, 3'b000, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 7'b0101000, 16'd3};
    vecs[8]  = '{4'b0000, 3'b000, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 7'b0000000, 16'd0};
    vecs[9]  = '{4'b0000, 3'b000, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 7'b0100000, 16'd1};
    vecs[10] = '{4'b0000, 3'b000, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 16'd0};
    vecs[11] = '{4'b0000, 3'b000, 3'b001, 1'b0, 1'b1, 1'b1, 1'b1, 7'b0010000, 16'd1};
    vecs[12] = '{4'b0000, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0000000, 16'd1};
    vecs[13] = '{4'b0010, 3'b111, 3'b111, 1'b0, 1'b1, 1'b1, 1'b1, 7'b0000010, 16'd1};

    #2;
    check("reset_block", 32'(block_a), 32'd0);
    check("reset_pulse", 32'(pulse_a), 32'd0);
    check("reset_src",   32'(src_a),   32'd0);
    check("reset_cyc",   32'(cyc_a),   32'd0);

    do_reset();
    for (int k = 0; k < 14; k++) begin
      drive(vecs[k].axis, vecs[k].idle, vecs[k].blk, vecs[k].clr, vecs[k].en);
      check($sformatf("v%0d_block", k), 32'(block_a), 32'(vecs[k].exp_block));
      check($sformatf("v%0d_pulse", k), 32'(pulse_a), 32'(vecs[k].exp_pulse));
      check($sformatf("v%0d_src", k),   32'(src_a),   32'(vecs[k].exp_src));
      check($sformatf("v%0d_cyc", k),   32'(cyc_a),   32'(vecs[k].exp_cyc));
    end

    // masked axis bit held for 20 cycles never trips the monitor
    do_reset();
    for (int k = 0; k < 20; k++) begin
      drive(4'b0001, 3'b000, 3'b000, 1'b0, 1'b1);
      check($sformatf("masked%0d_block", k), 32'(block_a), 32'd0);
    end

    // HOLD_CYCLES=4: 3 high, 1 low, 4 high, then 3 more high
    do_reset();
    npulse = 0;
    for (int k = 0; k < 11; k++) begin
      drive((k == 3) ? 4'b0000 : 4'b0100, 3'b000, 3'b000, 1'b0, 1'b1);
      check($sformatf("hold%0d_block", k), 32'(block_b), (k >= 7) ? 32'd1 : 32'd0);
      if (pulse_b) npulse++;
    end
    check("hold_pulses", 32'(npulse), 32'd1);
    check("hold_cyc", 32'(cyc_b), 32'd4);

    // STICKY=1: block persists after raw drops until clear
    do_reset();
    for (int k = 0; k < 5; k++) drive(4'b0100, 3'b000, 3'b000, 1'b0, 1'b1);
    check("sticky_block5", 32'(block_c), 32'd1);
    check("sticky_cyc5", 32'(cyc_c), 32'd5);
    for (int k = 0; k < 3; k++) drive(4'b0000, 3'b000, 3'b000, 1'b0, 1'b1);
    check("sticky_block_raw0", 32'(block_c), 32'd1);
    check("sticky_cyc8", 32'(cyc_c), 32'd8);
    drive(4'b0100, 3'b000, 3'b000, 1'b1, 1'b1);
    check("sticky_clr_block", 32'(block_c), 32'd0);
    check("sticky_clr_cyc", 32'(cyc_c), 32'd0);
    check("sticky_clr_src", 32'(src_c), 32'd0);
    drive(4'b0100, 3'b000, 3'b000, 1'b0, 1'b1);
    check("sticky_redetect_block", 32'(block_c), 32'd1);
    check("sticky_redetect_pulse", 32'(pulse_c), 32'd1);
    check("sticky_redetect_cyc", 32'(cyc_c), 32'd1);

    // CNT_W=3 saturation and async reset while blocked
    do_reset();
    for (int k = 0; k < 10; k++) drive(4'b1000, 3'b000, 3'b000, 1'b0, 1'b1);
    check("sat_block", 32'(block_d), 32'd1);
    check("sat_cyc", 32'(cyc_d), 32'd7);
    check("sat_src", 32'(src_d), 32'b0001000);
    #2 reset = 1'b1;
    #1;
    check("areset_block", 32'(block_d), 32'd0);
    check("areset_pulse", 32'(pulse_d), 32'd0);
    check("areset_src", 32'(src_d), 32'd0);
    check("areset_cyc", 32'(cyc_d), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
